// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the width helper for the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One extra bit beyond clog2 so the counter can hold WIDTH-1 at any WIDTH.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generated from the three input bits.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; operands captured when start is seen
// ST_RUN  | one operand bit per clock through the full_subtractor cell
// ST_DONE | one-cycle done pulse; diff/borrow_out already updated
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = count_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 bits completed so far; the last bit joins it
    // directly on the way into diff_q.
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             bin_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bout;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next-state decode and result shift-in value.
    always_comb begin
        state_d  = state_q;
        last_bit = (count_q == CW'(WIDTH - 1));
        res_next = {cell_d, res_sh};
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Operand capture, serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            bin_q    <= 1'b0;
            count_q  <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        bin_q   <= 1'b0;
                        count_q <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_next[WIDTH-1:1];
                    bin_q   <= cell_bout;
                    count_q <= count_q + 1'b1;
                    if (last_bit) begin
                        diff_q   <= res_next;
                        borrow_q <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=8) plus an
// exhaustive check of the full_subtractor cell.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    logic fa, fb, fbin, fd, fbout;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] prev_diff = 8'h00;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    full_subtractor u_fs (
        .a    (fa),
        .b    (fb),
        .bin  (fbin),
        .d    (fd),
        .bout (fbout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count negedges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One full operation starting from IDLE at a negedge.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb);
        int n;
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv;
        check("busy_after_start", busy, 1);
        check("diff_held_in_run", diff, prev_diff);
        wait_done(n);
        check("latency", n, 8);
        check("diff", diff, ed);
        check("borrow", borrow_out, eb);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_fall", busy, 0);
        check("diff_held_idle", diff, ed);
        prev_diff = ed;
    endtask

    initial begin
        int n;
        int dcount;
        int tmp;
        logic [7:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
        fa = 0; fb = 0; fbin = 0;

        // Exhaustive cell check against integer arithmetic.
        for (int i = 0; i < 8; i++) begin
            {fa, fb, fbin} = i[2:0];
            #1;
            tmp = int'(fa) - int'(fb) - int'(fbin);
            check("cell_d", fd, tmp & 1);
            check("cell_bout", fbout, (tmp < 0) ? 1 : 0);
        end

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h09, 8'h05, 8'h04, 1'b0);
        do_op(8'h05, 8'h09, 8'hFC, 1'b1);
        do_op(8'h00, 8'hFF, 8'h01, 1'b1);
        do_op(8'hFF, 8'h01, 8'hFE, 1'b0);
        do_op(8'h00, 8'h00, 8'h00, 1'b0);
        do_op(8'h80, 8'h01, 8'h7F, 1'b0);
        do_op(8'h7F, 8'h80, 8'hFF, 1'b1);

        // start held high, operands changed mid-run.
        start = 1'b1; a = 8'h30; b = 8'h10;
        @(negedge clk);
        a = 8'h01; b = 8'h02;
        wait_done(n);
        check("held_latency", n, 8);
        check("held_diff1", diff, 8'h20);
        check("held_borrow1", borrow_out, 0);
        a = 8'h50; b = 8'h20;
        @(negedge clk);
        n = 1;
        check("held_done_drop", done, 0);
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("held_spacing", n, 10);
        check("held_diff2", diff, 8'h30);
        check("held_borrow2", borrow_out, 0);
        @(negedge clk);
        check("held_busy_fall", busy, 0);
        prev_diff = 8'h30;

        // Leave a borrow of 1 so the reset clear is visible.
        do_op(8'h05, 8'h09, 8'hFC, 1'b1);

        // Reset in the middle of a run.
        start = 1'b1; a = 8'h0F; b = 8'h03;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("abort_no_done", dcount, 0);
        prev_diff = 8'h00;
        do_op(8'h0F, 8'h03, 8'h0C, 1'b0);

        // Random regression.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, 8'((int'(ra) - int'(rb) + 256) % 256), (ra < rb) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
